// File: rtl/id_ex_snapshot_dumper.sv
// Debug read-out for the ID/EX pipeline register. On request it freezes the
// register contents and streams them as a header/payload/checksum byte frame.
module id_ex_snapshot_dumper #(
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter bit         CHECKSUM_EN = 1'b1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         dumpReq,
  input  logic [132:0] snapIn,
  output logic [7:0]   txData,
  output logic         txValid,
  input  logic         txReady,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {IDLE, HDR, PAY, CHK, FIN} state_t;

  state_t         state, stateNext;
  logic [132:0]   snap, snapNext;
  logic [4:0]     cnt, cntNext;
  logic [7:0]     acc, accNext;
  logic [135:0]   payload;
  logic [7:0]     payByte;

  assign payload = {3'b000, snap};

  // Byte cnt of the payload, most significant byte first.
  always_comb begin
    payByte = '0;
    for (int unsigned i = 0; i < 17; i++) begin
      if (cnt == 5'(i)) payByte = payload[135 - 8*i -: 8];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      snap  <= '0;
      cnt   <= '0;
      acc   <= '0;
    end else begin
      state <= stateNext;
      snap  <= snapNext;
      cnt   <= cntNext;
      acc   <= accNext;
    end
  end

  // Outputs decode from the registered state only, so an async reset clears them at once.
  always_comb begin
    stateNext = state;
    snapNext  = snap;
    cntNext   = cnt;
    accNext   = acc;
    txData    = '0;
    txValid   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (dumpReq) begin
          snapNext  = snapIn;
          cntNext   = '0;
          accNext   = '0;
          stateNext = HDR;
        end
      end
      HDR: begin
        txData  = HEADER;
        txValid = 1'b1;
        busy    = 1'b1;
        if (txReady) stateNext = PAY;
      end
      PAY: begin
        txData  = payByte;
        txValid = 1'b1;
        busy    = 1'b1;
        if (txReady) begin
          accNext = acc ^ payByte;
          if (cnt == 5'd16) stateNext = CHECKSUM_EN ? CHK : FIN;
          else              cntNext   = cnt + 5'd1;
        end
      end
      CHK: begin
        txData  = acc;
        txValid = 1'b1;
        busy    = 1'b1;
        if (txReady) stateNext = FIN;
      end
      FIN: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_id_ex_snapshot_dumper.sv
// Directed bench for id_ex_snapshot_dumper: table-driven frames plus
// hand-written stall, reset, no-checksum and back-to-back sequences.
module tb_id_ex_snapshot_dumper;

  logic         clock, reset, dumpReq, txReady;
  logic [132:0] snapIn;
  logic [7:0]   txData, txData0;
  logic         txValid, busy, done, txValid0, busy0, done0;

  int checks = 0;
  int errors = 0;

  id_ex_snapshot_dumper #(.HEADER(8'hA5), .CHECKSUM_EN(1'b1)) dut (
    .clock(clock), .reset(reset), .dumpReq(dumpReq), .snapIn(snapIn),
    .txData(txData), .txValid(txValid), .txReady(txReady),
    .busy(busy), .done(done)
  );

  id_ex_snapshot_dumper #(.HEADER(8'hA5), .CHECKSUM_EN(1'b0)) dut0 (
    .clock(clock), .reset(reset), .dumpReq(dumpReq), .snapIn(snapIn),
    .txData(txData0), .txValid(txValid0), .txReady(txReady),
    .busy(busy0), .done(done0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [132:0] snap;
    logic [7:0]   chk;
    int           mode;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Consumes one frame starting at the current negedge; returns at the negedge showing done.
  task automatic runFrame(input logic [132:0] s, input logic [7:0] expChk, input int mode,
                          input bit pulse, input bit use0, input bit disturb);
    logic [7:0]   expB[19];
    logic [135:0] p;
    logic [7:0]   held, d;
    logic         v, dn, b;
    int           expN, nAcc, lastAcc;
    bit           stalled, sawDone;
    p = {3'b000, s};
    expB[0] = 8'hA5;
    for (int k = 0; k < 17; k++) expB[k+1] = p[135 - 8*k -: 8];
    expB[18] = expChk;
    expN = use0 ? 18 : 19;
    if (pulse) begin
      snapIn  = s;
      dumpReq = 1'b1;
      @(negedge clock);
      dumpReq = 1'b0;
      check("latency", use0 ? txValid0 : txValid, 1);
    end
    nAcc = 0; lastAcc = -10; stalled = 0; sawDone = 0; held = '0;
    for (int it = 0; it < 300 && !sawDone; it++) begin
      v  = use0 ? txValid0 : txValid;
      d  = use0 ? txData0  : txData;
      dn = use0 ? done0    : done;
      b  = use0 ? busy0    : busy;
      if (stalled) begin
        check("stallValid", v, 1);
        check("stallData", d, held);
      end
      if (dn) begin
        sawDone = 1;
        check("doneAfterLast", it, lastAcc + 1);
        check("byteCount", nAcc, expN);
        check("doneBusy", b, 0);
      end else begin
        if (v) check("busyWithValid", b, 1);
        txReady = (mode == 0) || (it % 3 == 0);
        if (disturb && it == 5) snapIn = ~s;
        if (disturb && it == 6) dumpReq = 1'b1;
        if (disturb && it == 7) dumpReq = 1'b0;
        if (v && txReady) begin
          if (nAcc < expN) check($sformatf("byte%0d", nAcc), d, expB[nAcc]);
          nAcc++;
          lastAcc = it;
          stalled = 0;
        end else begin
          stalled = v;
          held    = d;
        end
        @(negedge clock);
      end
    end
    if (!sawDone) check("frameTimeout", 0, 1);
  endtask

  task automatic waitIdle();
    bit ok;
    ok = 0;
    txReady = 1'b1;
    for (int it = 0; it < 100 && !ok; it++) begin
      if (!busy && !busy0 && !done && !done0 && !txValid && !txValid0) ok = 1;
      else @(negedge clock);
    end
    if (!ok) check("idleTimeout", 0, 1);
  endtask

  initial begin
    vecs[0] = '{133'h1, 8'h01, 0};
    vecs[1] = '{{4'hF, 129'b0}, 8'h1E, 0};
    vecs[2] = '{{133{1'b1}}, 8'h1F, 1};
    vecs[3] = '{133'h0123456789ABCDEF, 8'h00, 1};
    vecs[4] = '{{4'h5, 129'b0} | 133'h3C, 8'h36, 0};

    reset = 1'b1; dumpReq = 1'b0; txReady = 1'b0; snapIn = '0;
    #12;
    check("rstValid", txValid, 0);
    check("rstBusy", busy, 0);
    check("rstDone", done, 0);
    check("rstData", txData, 0);
    check("rstValid0", txValid0, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Table: each frame also perturbs snapIn and pulses dumpReq mid-frame.
    for (int i = 0; i < 5; i++) begin
      runFrame(vecs[i].snap, vecs[i].chk, vecs[i].mode, 1, 0, 1);
      @(negedge clock);
      check("donePulse", done, 0);
      check("busyAfter", busy, 0);
      waitIdle();
      for (int j = 0; j < 4; j++) begin
        check("noQueued", txValid, 0);
        @(negedge clock);
      end
    end

    // Reset while payload byte 8 is pending.
    snapIn = vecs[1].snap;
    dumpReq = 1'b1;
    @(negedge clock);
    dumpReq = 1'b0;
    begin
      int n;
      n = 0;
      for (int it = 0; it < 50 && n < 9; it++) begin
        txReady = 1'b1;
        if (txValid) n++;
        @(negedge clock);
      end
    end
    txReady = 1'b0;
    check("pendingBeforeReset", txValid, 1);
    check("pendingByte8", txData, 8'h00);
    #2 reset = 1'b1;
    #1;
    check("asyncRstValid", txValid, 0);
    check("asyncRstBusy", busy, 0);
    check("asyncRstData", txData, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    runFrame(vecs[0].snap, vecs[0].chk, 0, 1, 0, 0);
    waitIdle();

    // No-checksum instance, streaming and stalled.
    runFrame(vecs[4].snap, 8'h00, 0, 1, 1, 0);
    waitIdle();
    runFrame(vecs[1].snap, 8'h00, 1, 1, 1, 0);
    waitIdle();

    // dumpReq held high: next header appears two cycles after done.
    snapIn  = vecs[0].snap;
    dumpReq = 1'b1;
    @(negedge clock);
    runFrame(vecs[0].snap, vecs[0].chk, 0, 0, 0, 0);
    @(negedge clock);
    check("gapIdle", txValid, 0);
    @(negedge clock);
    check("restartValid", txValid, 1);
    check("restartHeader", txData, 8'hA5);
    dumpReq = 1'b0;
    runFrame(vecs[0].snap, vecs[0].chk, 0, 0, 0, 0);
    waitIdle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL globalTimeout: got running expected finished");
    $fatal(1);
  end

endmodule
